// File: rtl/core_sequencer.sv
// core_sequencer: opcode-aware multi-cycle control FSM for the 9-bit-instruction core.
// Steps fetch/decode/execute/memory/writeback and counts busy cycles and retired instructions.
module core_sequencer #(
    parameter logic [3:0] LOAD_OP     = 4'b0101,
    parameter logic [3:0] STORE_OP    = 4'b0110,
    parameter logic [3:0] BR_OP       = 4'b0111,
    parameter logic [3:0] HALT_OP     = 4'b1111,
    parameter int         MEM_TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        init_n,
    input  logic        go,
    input  logic [3:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_rst,
    output logic        pc_en,
    output logic        pc_load,
    output logic        ir_en,
    output logic        rf_wr_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        halt,
    output logic        err,
    output logic [15:0] cycle_ct,
    output logic [15:0] instr_ct
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmo_ct;
    logic [7:0] tmo_ct_nxt;
    logic       start;
    logic       retire;
    logic       tmo_hit;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state  <= S_IDLE;
            tmo_ct <= 8'd0;
        end else begin
            state  <= state_nxt;
            tmo_ct <= tmo_ct_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmo_ct_nxt = tmo_ct;
        start      = 1'b0;
        retire     = 1'b0;
        tmo_hit    = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        ir_en      = 1'b0;
        rf_wr_en   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        busy       = 1'b1;
        halt       = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    start     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_en     = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == HALT_OP) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else if (opcode == BR_OP) begin
                    retire    = 1'b1;
                    pc_load   = branch_taken;
                    pc_en     = !branch_taken;
                    state_nxt = S_FETCH;
                end else if (opcode == LOAD_OP || opcode == STORE_OP) begin
                    tmo_ct_nxt = 8'd0;
                    state_nxt  = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                // opcode is still the latched instruction here, so it selects read vs write
                mem_rd = (opcode == LOAD_OP);
                mem_wr = (opcode == STORE_OP);
                if (mem_ready) begin
                    if (opcode == LOAD_OP) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_en     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (tmo_ct == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    tmo_ct_nxt = tmo_ct + 8'd1;
                end
            end
            S_WB: begin
                rf_wr_en  = 1'b1;
                pc_en     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                busy = 1'b0;
                halt = 1'b1;
                if (go) begin
                    start     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // go reaches pc_rst combinationally, so mask it while reset is asserted
    assign pc_rst = start & init_n;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            err      <= 1'b0;
            cycle_ct <= 16'd0;
            instr_ct <= 16'd0;
        end else if (start) begin
            err      <= 1'b0;
            cycle_ct <= 16'd0;
            instr_ct <= 16'd0;
        end else begin
            if (tmo_hit) begin
                err <= 1'b1;
            end
            if (busy && cycle_ct != 16'hFFFF) begin
                cycle_ct <= cycle_ct + 16'd1;
            end
            if (retire && instr_ct != 16'hFFFF) begin
                instr_ct <= instr_ct + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench; each driven cycle pushes its expected output
// vector, and a negedge monitor pops and compares it against the DUT.
module tb_core_sequencer;

    localparam logic [3:0] LOAD_OP  = 4'b0101;
    localparam logic [3:0] STORE_OP = 4'b0110;
    localparam logic [3:0] BR_OP    = 4'b0111;
    localparam logic [3:0] HALT_OP  = 4'b1111;

    localparam logic [9:0] B_RST  = 10'b10_0000_0000;
    localparam logic [9:0] B_PCEN = 10'b01_0000_0000;
    localparam logic [9:0] B_LOAD = 10'b00_1000_0000;
    localparam logic [9:0] B_IR   = 10'b00_0100_0000;
    localparam logic [9:0] B_RF   = 10'b00_0010_0000;
    localparam logic [9:0] B_RD   = 10'b00_0001_0000;
    localparam logic [9:0] B_WR   = 10'b00_0000_1000;
    localparam logic [9:0] B_BUSY = 10'b00_0000_0100;
    localparam logic [9:0] B_HALT = 10'b00_0000_0010;
    localparam logic [9:0] B_ERR  = 10'b00_0000_0001;

    logic        CLK;
    logic        init_n;
    logic        go;
    logic [3:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        pc_rst, pc_en, pc_load, ir_en, rf_wr_en;
    logic        mem_rd, mem_wr, busy, halt, err;
    logic [15:0] cycle_ct;
    logic [15:0] instr_ct;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;

    core_sequencer dut (
        .CLK          (CLK),
        .init_n       (init_n),
        .go           (go),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .pc_rst       (pc_rst),
        .pc_en        (pc_en),
        .pc_load      (pc_load),
        .ir_en        (ir_en),
        .rf_wr_en     (rf_wr_en),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .busy         (busy),
        .halt         (halt),
        .err          (err),
        .cycle_ct     (cycle_ct),
        .instr_ct     (instr_ct)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [9:0] outVec();
        return {pc_rst, pc_en, pc_load, ir_en, rf_wr_en, mem_rd, mem_wr, busy, halt, err};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // strobe vector order: pc_rst pc_en pc_load ir_en rf_wr_en mem_rd mem_wr busy halt err
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            checkOutput(e.tag, {6'd0, outVec()}, {6'd0, e.exp});
        end
    end

    task automatic applyStimulus(input string tag, input logic g, input logic [3:0] op,
                                 input logic bt, input logic rdy, input logic [9:0] exp);
        go           = g;
        opcode       = op;
        branch_taken = bt;
        mem_ready    = rdy;
        sb_q.push_back('{tag, exp});
        @(posedge CLK);
        #1;
    endtask

    task automatic runAlu(input logic [3:0] op);
        applyStimulus("alu_f", 1'b0, op, 1'b0, 1'b0, B_BUSY | B_IR);
        applyStimulus("alu_d", 1'b0, op, 1'b0, 1'b0, B_BUSY);
        applyStimulus("alu_e", 1'b0, op, 1'b0, 1'b1, B_BUSY);
        applyStimulus("alu_wb", 1'b0, op, 1'b0, 1'b0, B_BUSY | B_RF | B_PCEN);
    endtask

    task automatic runBranch(input logic bt);
        applyStimulus("br_f", 1'b0, BR_OP, bt, 1'b0, B_BUSY | B_IR);
        applyStimulus("br_d", 1'b0, BR_OP, bt, 1'b0, B_BUSY);
        applyStimulus("br_e", 1'b0, BR_OP, bt, 1'b0, bt ? (B_BUSY | B_LOAD) : (B_BUSY | B_PCEN));
    endtask

    task automatic runHaltOp();
        applyStimulus("hlt_f", 1'b0, HALT_OP, 1'b0, 1'b0, B_BUSY | B_IR);
        applyStimulus("hlt_d", 1'b0, HALT_OP, 1'b0, 1'b0, B_BUSY);
        applyStimulus("hlt_e", 1'b0, HALT_OP, 1'b0, 1'b0, B_BUSY);
    endtask

    task automatic runLoad(input int n);
        applyStimulus("ld_f", 1'b0, LOAD_OP, 1'b0, 1'b1, B_BUSY | B_IR);
        applyStimulus("ld_d", 1'b0, LOAD_OP, 1'b0, 1'b1, B_BUSY);
        applyStimulus("ld_e", 1'b0, LOAD_OP, 1'b0, 1'b1, B_BUSY);
        for (int i = 1; i <= n; i++)
            applyStimulus("ld_mem", 1'b0, LOAD_OP, 1'b0, (i == n), B_BUSY | B_RD);
        applyStimulus("ld_wb", 1'b0, LOAD_OP, 1'b0, 1'b0, B_BUSY | B_RF | B_PCEN);
    endtask

    task automatic runStore(input int n);
        applyStimulus("st_f", 1'b0, STORE_OP, 1'b0, 1'b1, B_BUSY | B_IR);
        applyStimulus("st_d", 1'b0, STORE_OP, 1'b0, 1'b1, B_BUSY);
        applyStimulus("st_e", 1'b0, STORE_OP, 1'b0, 1'b1, B_BUSY);
        for (int i = 1; i <= n; i++)
            applyStimulus("st_mem", 1'b0, STORE_OP, 1'b0, (i == n),
                          (i == n) ? (B_BUSY | B_WR | B_PCEN) : (B_BUSY | B_WR));
    endtask

    initial begin
        init_n       = 1'b0;
        go           = 1'b0;
        opcode       = 4'h0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        @(posedge CLK);
        #1;

        // reset held 3 cycles; go during reset must not leak a pc_rst
        applyStimulus("rst0", 1'b0, 4'h0, 1'b0, 1'b0, 10'd0);
        applyStimulus("rst1", 1'b1, 4'h0, 1'b0, 1'b1, 10'd0);
        applyStimulus("rst2", 1'b0, 4'h0, 1'b0, 1'b0, 10'd0);
        checkOutput("rst_cyc", cycle_ct, 16'd0);
        checkOutput("rst_ins", instr_ct, 16'd0);
        init_n = 1'b1;

        applyStimulus("idle", 1'b0, 4'h0, 1'b0, 1'b1, 10'd0);
        applyStimulus("go", 1'b1, 4'h0, 1'b0, 1'b0, B_RST);
        checkOutput("go_cyc", cycle_ct, 16'd0);
        checkOutput("go_ins", instr_ct, 16'd0);

        // ALU, ALU, HALT: 4 + 4 + 3 busy cycles
        runAlu(4'b0000);
        runAlu(4'b0001);
        runHaltOp();
        checkOutput("prog1_cyc", cycle_ct, 16'd11);
        checkOutput("prog1_ins", instr_ct, 16'd3);
        applyStimulus("halt1", 1'b0, 4'h0, 1'b0, 1'b1, B_HALT);

        applyStimulus("restart1", 1'b1, 4'h0, 1'b0, 1'b0, B_HALT | B_RST);
        checkOutput("restart1_cyc", cycle_ct, 16'd0);
        runLoad(3);
        checkOutput("ld3_cyc", cycle_ct, 16'd7);
        runStore(1);
        runBranch(1'b1);
        runBranch(1'b0);
        runHaltOp();
        checkOutput("prog2_cyc", cycle_ct, 16'd20);
        checkOutput("prog2_ins", instr_ct, 16'd5);
        applyStimulus("halt2", 1'b0, 4'h0, 1'b0, 1'b0, B_HALT);

        // memory timeout: 8 MEM cycles without ready, then HALT with err
        applyStimulus("restart2", 1'b1, 4'h0, 1'b0, 1'b0, B_HALT | B_RST);
        applyStimulus("to_f", 1'b0, LOAD_OP, 1'b0, 1'b0, B_BUSY | B_IR);
        applyStimulus("to_d", 1'b0, LOAD_OP, 1'b0, 1'b0, B_BUSY);
        applyStimulus("to_e", 1'b0, LOAD_OP, 1'b0, 1'b0, B_BUSY);
        for (int i = 0; i < 8; i++)
            applyStimulus("to_mem", 1'b0, LOAD_OP, 1'b0, 1'b0, B_BUSY | B_RD);
        checkOutput("to_cyc", cycle_ct, 16'd11);
        checkOutput("to_ins", instr_ct, 16'd0);
        applyStimulus("to_halt", 1'b0, LOAD_OP, 1'b0, 1'b1, B_HALT | B_ERR);
        applyStimulus("restart3", 1'b1, 4'h0, 1'b0, 1'b0, B_HALT | B_ERR | B_RST);

        // ready on the last allowed MEM cycle completes normally
        runLoad(8);
        runAlu(4'b0011);
        runHaltOp();
        checkOutput("prog3_cyc", cycle_ct, 16'd19);
        checkOutput("prog3_ins", instr_ct, 16'd3);
        applyStimulus("halt3", 1'b0, 4'h0, 1'b0, 1'b0, B_HALT);

        // async reset during the 2nd MEM cycle of a store
        applyStimulus("restart4", 1'b1, 4'h0, 1'b0, 1'b0, B_HALT | B_RST);
        runAlu(4'b0010);
        applyStimulus("ar_f", 1'b0, STORE_OP, 1'b0, 1'b0, B_BUSY | B_IR);
        applyStimulus("ar_d", 1'b0, STORE_OP, 1'b0, 1'b0, B_BUSY);
        applyStimulus("ar_e", 1'b0, STORE_OP, 1'b0, 1'b0, B_BUSY);
        applyStimulus("ar_mem1", 1'b0, STORE_OP, 1'b0, 1'b0, B_BUSY | B_WR);
        #1;
        checkOutput("ar_mem2_wr", {15'd0, mem_wr}, 16'd1);
        init_n = 1'b0;
        #1;
        checkOutput("ar_outs", {6'd0, outVec()}, 16'd0);
        checkOutput("ar_cyc", cycle_ct, 16'd0);
        checkOutput("ar_ins", instr_ct, 16'd0);
        @(posedge CLK);
        #1;
        init_n = 1'b1;
        applyStimulus("ar_idle", 1'b0, STORE_OP, 1'b0, 1'b1, 10'd0);
        applyStimulus("ar_go", 1'b1, 4'h0, 1'b0, 1'b0, B_RST);
        applyStimulus("ar_fetch", 1'b0, 4'h0, 1'b0, 1'b0, B_BUSY | B_IR);

        @(negedge CLK);
        #1;
        checkOutput("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
